// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner with prefetch FIFO, decode handshake and redirect/fault handling
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_a,
  input  logic [31:0]                imem_rd,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_pc,
  output logic                       if_fault,
  output logic [$clog2(DEPTH):0]     fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, FLT_PUSH, FLT_HOLD} state_t;

  state_t          state_q;
  logic [31:0]     pc_q, pc_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pc_m    [DEPTH];
  logic [31:0]     instr_m [DEPTH];
  logic            flt_m   [DEPTH];
  logic            pop, push, full, push_flt;

  assign imem_a   = pc_q;
  assign fq_count = cnt_q;
  assign if_valid = cnt_q != '0;
  assign if_instr = if_valid ? instr_m[rd_q] : NOP;
  assign if_pc    = if_valid ? pc_m[rd_q] : 32'h0;
  assign if_fault = if_valid & flt_m[rd_q];

  // Next-state for PC, pointers and occupancy; a redirect flushes and overrides everything
  always_comb begin
    pop      = if_valid & if_ready;
    full     = cnt_q == CW'(DEPTH);
    push_flt = state_q == FLT_PUSH;
    push     = !redirect_valid & fetch_en &
               (((state_q == RUN) & (!full | pop)) | (push_flt & !full));
    pc_d     = redirect_valid ? redirect_pc : (push & !push_flt) ? pc_q + 32'd4 : pc_q;
    wr_d     = redirect_valid ? '0 : push ? wr_q + AW'(1) : wr_q;
    rd_d     = redirect_valid ? '0 : pop ? rd_q + AW'(1) : rd_q;
    cnt_d    = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
  end

  // Fetch control FSM: misaligned redirect pushes one fault marker, then parks until an aligned redirect
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else if (redirect_valid) state_q <= (redirect_pc[1:0] != 2'b00) ? FLT_PUSH : RUN;
    else if (push_flt && push) state_q <= FLT_HOLD;
  end

  // PC, pointer and count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; fault markers carry a NOP so decode never sees stale memory data
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_m[wr_q]    <= pc_q;
      instr_m[wr_q] <= push_flt ? NOP : imem_rd;
      flt_m[wr_q]   <= push_flt;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand sequences for wrap, toggle and mid-run reset
module tb_fetch_queue;
  logic        clk = 0;
  logic        rst_n, fetch_en, redirect_valid, if_ready;
  logic [31:0] redirect_pc, imem_a, imem_rd, if_instr, if_pc;
  logic        if_valid, if_fault;
  logic [2:0]  fq_count;

  logic        rst2_n = 0;
  logic [31:0] imem_a2, imem_rd2, if_instr2, if_pc2;
  logic        if_valid2, if_fault2;
  logic [2:0]  fq_count2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rd  = imem_a >> 2;
  assign imem_rd2 = imem_a2 >> 2;

  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_a(imem_a), .imem_rd(imem_rd), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault), .fq_count(fq_count)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_a(imem_a2), .imem_rd(imem_rd2), .fetch_en(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .if_valid(if_valid2),
    .if_ready(1'b1), .if_instr(if_instr2), .if_pc(if_pc2), .if_fault(if_fault2), .fq_count(fq_count2)
  );

  typedef struct {
    logic        rst_n, en, rv, rdy;
    logic [31:0] rpc;
    logic        ev, ef;
    logic [31:0] epc, ei, ea;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, en, rv, rdy, input logic [31:0] rpc,
                     input logic ev, ef, input logic [31:0] epc, ei, ea, input logic [2:0] ec);
    vec_t v;
    v.rst_n = r; v.en = en; v.rv = rv; v.rdy = rdy; v.rpc = rpc;
    v.ev = ev; v.ef = ef; v.epc = epc; v.ei = ei; v.ea = ea; v.ec = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst_n = 0; fetch_en = 1; redirect_valid = 0; redirect_pc = 0; if_ready = 1;
    #1;
    // reset then streaming with ready high
    add(0,1,0,1,0,       0,0,0,32'h13,0,0);
    add(1,1,0,1,0,       1,0,0,0,4,1);
    add(1,1,0,1,0,       1,0,4,1,8,1);
    add(1,1,0,1,0,       1,0,8,2,32'hC,1);
    // backpressure for ten cycles, then drain
    add(0,1,0,0,0,       0,0,0,32'h13,0,0);
    add(1,1,0,0,0,       1,0,0,0,4,1);
    add(1,1,0,0,0,       1,0,0,0,8,2);
    add(1,1,0,0,0,       1,0,0,0,32'hC,3);
    add(1,1,0,0,0,       1,0,0,0,32'h10,4);
    for (int i = 0; i < 6; i++) add(1,1,0,0,0, 1,0,0,0,32'h10,4);
    add(1,1,0,1,0,       1,0,4,1,32'h14,4);
    add(1,1,0,1,0,       1,0,8,2,32'h18,4);
    add(1,1,0,1,0,       1,0,32'hC,3,32'h1C,4);
    add(1,1,0,1,0,       1,0,32'h10,4,32'h20,4);
    // full queue, pop and redirect together
    add(1,1,1,1,32'h80,  0,0,0,32'h13,32'h80,0);
    add(1,1,0,1,0,       1,0,32'h80,32'h20,32'h84,1);
    // misaligned redirect: one fault marker, then hold
    add(1,1,1,0,32'h82,  0,0,0,32'h13,32'h82,0);
    add(1,1,0,0,0,       1,1,32'h82,32'h13,32'h82,1);
    add(1,1,0,0,0,       1,1,32'h82,32'h13,32'h82,1);
    add(1,1,0,1,0,       0,0,0,32'h13,32'h82,0);
    add(1,1,0,1,0,       0,0,0,32'h13,32'h82,0);
    add(1,1,1,1,32'h100, 0,0,0,32'h13,32'h100,0);
    add(1,1,0,1,0,       1,0,32'h100,32'h40,32'h104,1);
    // fetch_en low: pop continues, PC held
    add(1,0,0,1,0,       0,0,0,32'h13,32'h104,0);
    add(1,1,0,1,0,       1,0,32'h104,32'h41,32'h108,1);

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; fetch_en = tbl[k].en; redirect_valid = tbl[k].rv;
      redirect_pc = tbl[k].rpc; if_ready = tbl[k].rdy;
      tick();
      chk($sformatf("v%0d valid", k), 32'(if_valid), 32'(tbl[k].ev));
      chk($sformatf("v%0d fault", k), 32'(if_fault), 32'(tbl[k].ef));
      chk($sformatf("v%0d pc", k), if_pc, tbl[k].epc);
      chk($sformatf("v%0d instr", k), if_instr, tbl[k].ei);
      chk($sformatf("v%0d imem_a", k), imem_a, tbl[k].ea);
      chk($sformatf("v%0d count", k), 32'(fq_count), 32'(tbl[k].ec));
    end

    // PC wrap past 0xFFFF_FFFC on the second instance
    rst2_n = 0;
    tick();
    chk("wrap reset imem_a", imem_a2, 32'hFFFF_FFF8);
    rst2_n = 1;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap pc%0d", i), if_pc2, exp_pc);
      chk($sformatf("wrap instr%0d", i), if_instr2, exp_pc >> 2);
      exp_pc = exp_pc + 32'd4;
    end

    // fetch_en toggling with intermittent ready: popped PCs must be contiguous
    rst_n = 0; fetch_en = 1; redirect_valid = 0; if_ready = 1;
    tick();
    rst_n = 1;
    exp_pc = 0;
    for (int i = 0; i < 30; i++) begin
      fetch_en = i[0];
      if_ready = (i % 3) != 2;
      if (if_valid && if_ready) begin
        chk("toggle pc", if_pc, exp_pc);
        chk("toggle instr", if_instr, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    chk("toggle progress", 32'(exp_pc >= 32'h20), 32'd1);
    fetch_en = 0; if_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("drained count", 32'(fq_count), 0);
    fetch_en = 1; if_ready = 0;
    tick();
    tick();
    chk("half full count", 32'(fq_count), 2);
    rst_n = 0;
    tick();
    chk("mid reset valid", 32'(if_valid), 0);
    chk("mid reset count", 32'(fq_count), 0);
    chk("mid reset imem_a", imem_a, 32'h0);
    chk("mid reset fault", 32'(if_fault), 0);
    rst_n = 1; if_ready = 1;
    tick();
    chk("post reset pc", if_pc, 32'h0);
    chk("post reset valid", 32'(if_valid), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
